user_cmd_bank: RTL and testbench

//  Parametrised user-register command bank between the SPI user-register file and acquisition/accumulation logic.

---
 rtl/cmd_bank_pkg.sv | 20 ++
 rtl/cmd_bank_settle_filter.sv | 57 +++++
 rtl/user_cmd_bank.sv | 138 +++++++++++++
 tb/tb_user_cmd_bank.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_bank_pkg.sv
// Shared types and helpers for the user-register command bank.
//   state_e      : bank FSM states
//   COMMIT_CNT_W : width of the commit counter
//   reg_slice()  : extract register i of width w from a packed register bus
package cmd_bank_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, PENDING, APPLY} state_e;

  localparam int COMMIT_CNT_W = 16;

  // Upper bounds for reg_slice; callers zero-extend the bus and truncate the result.
  localparam int MAX_BUS_W = 4096;
  localparam int MAX_REG_W = 64;

  function automatic logic [MAX_REG_W-1:0] reg_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int i, input int w);
    return MAX_REG_W'(bus >> (i * w));
  endfunction

endpackage

// File: rtl/cmd_bank_settle_filter.sv
// cmd_settle_filter: input register plus stability filter.
//   data_i  : raw register bus, registered into in_q every cycle
//   load_i  : restart filtering (cand <= in_q, counter cleared)
//   count_i : advance the stability counter
//   in_q_o  : registered input bus
//   cand_o  : candidate value under observation
//   diff_o  : in_q differs from the candidate
//   done_o  : candidate has been stable for STABLE_CYC cycles
module cmd_settle_filter #(
  parameter int BUS_W      = 128,
  parameter int STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] data_i,
  input  logic             load_i,
  input  logic             count_i,
  output logic [BUS_W-1:0] in_q_o,
  output logic [BUS_W-1:0] cand_o,
  output logic             diff_o,
  output logic             done_o
);
  // One extra bit keeps CNT_W >= 1 even for STABLE_CYC == 1.
  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic [BUS_W-1:0] in_q, cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      cand_d = in_q;
      cnt_d  = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      in_q   <= data_i;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_q_o = in_q;
  assign cand_o = cand_q;
  assign diff_o = (in_q != cand_q);
  assign done_o = (cnt_q == CNT_W'(STABLE_CYC - 1));

endmodule

// File: rtl/user_cmd_bank.sv
// user_cmd_bank: filters SPI user-register writes, holds a stable set as
// pending, and commits the whole set atomically while update_disable is low.
//   user_register_i : raw register file, reg i at [(i+1)*REG_W-1 : i*REG_W]
//   update_disable  : 1 = frame in progress, commits blocked
//   ur_active_o     : committed register set
//   ur_changed_o    : per-register changed mask of the last commit
//   cmd_updated_o   : 1-cycle pulse per commit
//   cmd_strobe_o    : 1-cycle pulse on a commit that changed register CMD_IDX
//   pending_o       : a settled set is waiting for update_disable to fall
//   commit_cnt_o    : wrapping commit counter
module user_cmd_bank
  import cmd_bank_pkg::*;
#(
  parameter int N_REGS     = 8,
  parameter int REG_W      = 16,
  parameter int STABLE_CYC = 4,
  parameter int CMD_IDX    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    update_disable,
  input  logic [N_REGS*REG_W-1:0] user_register_i,
  output logic [N_REGS*REG_W-1:0] ur_active_o,
  output logic [N_REGS-1:0]       ur_changed_o,
  output logic                    cmd_updated_o,
  output logic                    cmd_strobe_o,
  output logic                    pending_o,
  output logic [COMMIT_CNT_W-1:0] commit_cnt_o
);
  localparam int BUS_W = N_REGS * REG_W;

  state_e                  state_q, state_d;
  logic [BUS_W-1:0]        shadow_q, shadow_d, active_q, active_d;
  logic [N_REGS-1:0]       changed_q, changed_d, changed_vec;
  logic                    upd_q, upd_d, strobe_q, strobe_d;
  logic [COMMIT_CNT_W-1:0] commit_cnt_q, commit_cnt_d;

  logic [BUS_W-1:0] in_q, cand;
  logic             load, count, diff, done;

  cmd_settle_filter #(.BUS_W(BUS_W), .STABLE_CYC(STABLE_CYC)) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (user_register_i),
    .load_i  (load),
    .count_i (count),
    .in_q_o  (in_q),
    .cand_o  (cand),
    .diff_o  (diff),
    .done_o  (done)
  );

  for (genvar i = 0; i < N_REGS; i++) begin : g_mask
    assign changed_vec[i] =
      REG_W'(reg_slice(MAX_BUS_W'(shadow_q), i, REG_W)) !=
      REG_W'(reg_slice(MAX_BUS_W'(active_q), i, REG_W));
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    changed_d    = changed_q;
    upd_d        = 1'b0;
    strobe_d     = 1'b0;
    commit_cnt_d = commit_cnt_q;
    load         = 1'b0;
    count        = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_q != active_q) begin
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (diff) begin
          load = 1'b1;
          // Input went back to the committed set: nothing to commit.
          if (in_q == active_q) state_d = IDLE;
        end else if (cand == active_q) begin
          state_d = IDLE;
        end else if (done) begin
          shadow_d = cand;
          state_d  = PENDING;
        end else begin
          count = 1'b1;
        end
      end
      PENDING: begin
        // A new input beats a simultaneous update_disable release.
        if (in_q != shadow_q) begin
          load    = 1'b1;
          state_d = SETTLE;
        end else if (!update_disable) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        active_d     = shadow_q;
        changed_d    = changed_vec;
        upd_d        = 1'b1;
        strobe_d     = changed_vec[CMD_IDX];
        commit_cnt_d = commit_cnt_q + COMMIT_CNT_W'(1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
      changed_q    <= '0;
      upd_q        <= 1'b0;
      strobe_q     <= 1'b0;
      commit_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      changed_q    <= changed_d;
      upd_q        <= upd_d;
      strobe_q     <= strobe_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign ur_active_o   = active_q;
  assign ur_changed_o  = changed_q;
  assign cmd_updated_o = upd_q;
  assign cmd_strobe_o  = strobe_q;
  assign pending_o     = (state_q == PENDING);
  assign commit_cnt_o  = commit_cnt_q;

endmodule

// File: tb/tb_user_cmd_bank.sv
// Self-checking bench for user_cmd_bank: table-driven single-register writes
// plus hand-written glitch, blocked, race, wrap and mid-op reset sequences.
// Expected commits go into a scoreboard queue and are checked when
// cmd_updated_o pulses.
module tb_user_cmd_bank;
  localparam int N = 8;
  localparam int W = 16;
  localparam int S = 4;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          update_disable = 1'b0;
  logic [BW-1:0] user_register_i = '0;
  logic [BW-1:0] ur_active_o;
  logic [N-1:0]  ur_changed_o;
  logic          cmd_updated_o, cmd_strobe_o, pending_o;
  logic [15:0]   commit_cnt_o;

  user_cmd_bank #(.N_REGS(N), .REG_W(W), .STABLE_CYC(S), .CMD_IDX(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .update_disable  (update_disable),
    .user_register_i (user_register_i),
    .ur_active_o     (ur_active_o),
    .ur_changed_o    (ur_changed_o),
    .cmd_updated_o   (cmd_updated_o),
    .cmd_strobe_o    (cmd_strobe_o),
    .pending_o       (pending_o),
    .commit_cnt_o    (commit_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] active;
    logic [N-1:0]  changed;
    logic          strobe;
    logic [15:0]   cnt;
  } exp_t;

  typedef struct {
    int          idx;
    logic [15:0] val;
    bit          commit;
    logic [N-1:0] mask;
    bit          strobe;
  } vec_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [15:0] model[N];
  int          exp_cnt = 0;
  int          n_cmp = 0, n_bad = 0, n_upd = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_model();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) b[i*W +: W] = model[i];
    return b;
  endfunction

  task automatic push_exp(input logic [N-1:0] mask, input bit strobe);
    exp_t e;
    exp_cnt++;
    e.active  = pack_model();
    e.changed = mask;
    e.strobe  = strobe;
    e.cnt     = 16'(exp_cnt);
    sb.push_back(e);
  endtask

  // Counts negedges until cmd_updated_o is seen; a missing pulse reports latency 0.
  task automatic wait_commit(input string nm, input int exp_lat, input int bound);
    int lat;
    lat = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (cmd_updated_o) begin
        lat = c;
        break;
      end
    end
    chk({nm, " latency"}, BW'(lat), BW'(exp_lat));
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_updated_o) begin
        n_upd++;
        chk("sb nonempty at commit", BW'(sb.size() > 0), BW'(1));
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          chk("commit active", ur_active_o, e_mon.active);
          chk("commit changed", BW'(ur_changed_o), BW'(e_mon.changed));
          chk("commit strobe", BW'(cmd_strobe_o), BW'(e_mon.strobe));
          chk("commit count", BW'(commit_cnt_o), BW'(e_mon.cnt));
        end
      end else if (cmd_strobe_o) begin
        chk("strobe without update", BW'(cmd_updated_o), BW'(1));
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, " active"},  ur_active_o, '0);
    chk({nm, " changed"}, BW'(ur_changed_o), '0);
    chk({nm, " pulses"},  BW'({cmd_updated_o, cmd_strobe_o}), '0);
    chk({nm, " pending"}, BW'(pending_o), '0);
    chk({nm, " count"},   BW'(commit_cnt_o), '0);
  endtask

  vec_t vt[6];

  initial begin
    int n0, viol;
    logic [BW-1:0] old;

    vt[0] = '{0, 16'h0001, 1'b1, 8'h01, 1'b1};
    vt[1] = '{7, 16'h00AA, 1'b1, 8'h80, 1'b0};
    vt[2] = '{2, 16'h5555, 1'b1, 8'h04, 1'b0};
    vt[3] = '{2, 16'h5555, 1'b0, 8'h00, 1'b0};
    vt[4] = '{0, 16'h0002, 1'b1, 8'h01, 1'b1};
    vt[5] = '{0, 16'h0002, 1'b0, 8'h00, 1'b0};

    // Reset with all-ones input, then release: whole set commits.
    for (int i = 0; i < N; i++) model[i] = 16'hFFFF;
    user_register_i = pack_model();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    push_exp({N{1'b1}}, 1'b1);
    rst_n = 1'b1;
    wait_commit("reset release", S + 4, 30);

    // Table of single-register writes.
    for (int v = 0; v < 6; v++) begin
      repeat (2) @(negedge clk);
      model[vt[v].idx] = vt[v].val;
      n0 = n_upd;
      if (vt[v].commit) push_exp(vt[v].mask, vt[v].strobe);
      user_register_i = pack_model();
      if (vt[v].commit) wait_commit($sformatf("vec%0d", v), S + 4, 30);
      else begin
        repeat (16) @(negedge clk);
        chk($sformatf("vec%0d no pulse", v), BW'(n_upd), BW'(n0));
      end
      chk($sformatf("vec%0d active", v), ur_active_o, pack_model());
    end

    // Glitch: reg3 changes twice during settling, one commit of the final value.
    repeat (2) @(negedge clk);
    n0 = n_upd;
    model[3] = 16'h0010;
    user_register_i = pack_model();
    repeat (2) @(negedge clk);
    model[3] = 16'h0020;
    push_exp(8'h08, 1'b0);
    user_register_i = pack_model();
    wait_commit("glitch", S + 4, 30);
    repeat (10) @(negedge clk);
    chk("glitch single commit", BW'(n_upd), BW'(n0 + 1));
    chk("changed held after pulse", BW'(ur_changed_o), BW'(8'h08));

    // Blocked: value settles and waits while update_disable is high.
    update_disable = 1'b1;
    old = ur_active_o;
    n0 = n_upd;
    model[5] = 16'h1234;
    push_exp(8'h20, 1'b0);
    user_register_i = pack_model();
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (ur_active_o !== old) viol++;
    end
    chk("blocked active unchanged", BW'(viol), '0);
    chk("blocked no pulse", BW'(n_upd), BW'(n0));
    chk("blocked pending", BW'(pending_o), BW'(1));
    chk("blocked changed held", BW'(ur_changed_o), BW'(8'h08));
    update_disable = 1'b0;
    wait_commit("unblock", 2, 10);
    chk("pending cleared", BW'(pending_o), '0);

    // Race: input change reaches PENDING in the same cycle update_disable falls.
    repeat (2) @(negedge clk);
    update_disable = 1'b1;
    model[1] = 16'h0BEE;
    user_register_i = pack_model();
    repeat (12) @(negedge clk);
    chk("race pending", BW'(pending_o), BW'(1));
    model[1] = 16'h0CAF;
    push_exp(8'h02, 1'b0);
    user_register_i = pack_model();
    @(negedge clk);
    update_disable = 1'b0;
    wait_commit("race", S + 3, 30);

    // Counter wrap from a preloaded 0xFFFF.
    repeat (2) @(negedge clk);
    force dut.commit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.commit_cnt_q;
    exp_cnt = 16'hFFFF;
    model[6] = 16'h0666;
    push_exp(8'h40, 1'b0);
    user_register_i = pack_model();
    wait_commit("wrap", S + 4, 30);

    // Reset asserted mid-settle: everything clears, nothing commits afterwards.
    repeat (2) @(negedge clk);
    model[4] = 16'h4444;
    user_register_i = pack_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    user_register_i = '0;
    for (int i = 0; i < N; i++) model[i] = 16'h0000;
    #1;
    chk_all_zero("mid-op reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_upd;
    repeat (20) @(negedge clk);
    chk("post-reset no pulse", BW'(n_upd), BW'(n0));
    chk("post-reset active", ur_active_o, '0);
    chk("post-reset pending", BW'(pending_o), '0);
    chk("scoreboard drained", BW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
